// File: rtl/deca_enet_reset_master_pkg.sv
// -----------------------------------------------------------------------------
// deca_enet_rst_pkg
// Shared definitions for the Ethernet PHY reset sequencer:
//   - rst_state_t       : sequencer state encoding
//   - DEF_*_CYCLES      : default hold / settle / readback-timeout lengths
//   - PIO_ASSERT_DATA   : value written to nENET to put the PHY in reset (0)
//   - PIO_RELEASE_DATA  : value written to nENET to release the PHY (1)
//   - max3()            : sizing helper for the shared cycle timer
// -----------------------------------------------------------------------------
package deca_enet_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_ASSERT  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_WR_RELEASE = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_RD_REQ     = 3'd5,
    ST_RD_WAIT    = 3'd6,
    ST_FINISH     = 3'd7
  } rst_state_t;

  localparam int DEF_ASSERT_CYCLES  = 1000;
  localparam int DEF_SETTLE_CYCLES  = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // nENET is active-low: 0 holds the PHY in reset, 1 lets it run.
  localparam logic [31:0] PIO_ASSERT_DATA  = 32'd0;
  localparam logic [31:0] PIO_RELEASE_DATA = 32'd1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/deca_enet_reset_master_if.sv
// -----------------------------------------------------------------------------
// deca_enet_reset_master_if
// Avalon-MM bus between the reset sequencer (master) and the fabric (slave).
//   avm_address       : byte address, ADDR_W bits
//   avm_write         : write request
//   avm_read          : read request
//   avm_writedata     : 32-bit write data
//   avm_waitrequest   : slave stall
//   avm_readdata      : 32-bit read data
//   avm_readdatavalid : read data valid
// -----------------------------------------------------------------------------
interface deca_enet_reset_master_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/deca_enet_reset_master_timer.sv
// -----------------------------------------------------------------------------
// deca_cycle_timer
// Loadable down-counter that stops at 0 (never wraps).
//   clk      : clock
//   reset    : synchronous active-high, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one if not already 0
//   zero     : count == 0
//   one      : count == 1 (the current cycle is the last one of the interval)
// -----------------------------------------------------------------------------
module deca_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);
  assign one  = (count_reg == W'(1));

endmodule

// File: rtl/deca_enet_reset_master.sv
// -----------------------------------------------------------------------------
// deca_enet_reset_master
// Avalon-MM initiator that pulses the Ethernet PHY hardware reset through the
// single-bit nENET PIO: write 0, hold ASSERT_CYCLES, write 1, wait
// SETTLE_CYCLES, optionally read the register back, then pulse done.
//
// Build option: define DECA_ENET_RST_READBACK_EN to include the readback
// (RD_REQ/RD_WAIT, functional error flag and TIMEOUT_CYCLES). Without it,
// SETTLE goes straight to FINISH, avm_read is 0 and error is 0.
//
// Ports:
//   clk    : sole clock
//   reset  : synchronous active-high reset
//   start  : request pulse, only sampled in IDLE
//   busy   : sequence in progress (not in IDLE/FINISH)
//   done   : one-cycle completion pulse
//   error  : readback mismatch or timeout, held until the next accepted start
//   avm    : Avalon-MM master port (deca_enet_reset_master_if.master)
// All outputs are registered.
// -----------------------------------------------------------------------------
module deca_enet_reset_master
  import deca_enet_rst_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] PIO_ADDR       = '0,
  parameter int                ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
  parameter int                SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  deca_enet_reset_master_if.master avm
);

`ifdef DECA_ENET_RST_READBACK_EN
  localparam int CNT_MAX = max3(ASSERT_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = max3(ASSERT_CYCLES, SETTLE_CYCLES, 1);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ASSERT_LD = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
`ifdef DECA_ENET_RST_READBACK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
`endif

  rst_state_t        state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;
  logic              tmr_one;
  logic              tmr_expire;

  // One timer serves HOLD, SETTLE and the readback timeout. It is loaded on
  // the cycle the preceding bus request is accepted, so a value of N yields
  // exactly N cycles in the following wait state.
  deca_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  // Last cycle of a wait interval; zero is included so a cleared counter can
  // never stall the sequence.
  assign tmr_expire = tmr_one || tmr_zero;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_reg)
      ST_WR_ASSERT: begin
        if (!avm.avm_waitrequest) begin
          tmr_load = 1'b1;
          tmr_val  = ASSERT_LD;
        end
      end
      ST_WR_RELEASE: begin
        if (!avm.avm_waitrequest) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_HOLD, ST_SETTLE: tmr_dec = 1'b1;
`ifdef DECA_ENET_RST_READBACK_EN
      ST_RD_REQ: begin
        if (!avm.avm_waitrequest) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LD;
        end
      end
      ST_RD_WAIT: tmr_dec = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef DECA_ENET_RST_READBACK_EN
  logic read_reg;
  logic error_reg;
  logic unused_rdata;
  assign unused_rdata = ^avm.avm_readdata[31:1];
`else
  logic unused_rb;
  assign unused_rb = ^{avm.avm_readdata, avm.avm_readdatavalid};
`endif

  // Outputs are set on the transition into the state that owns them, so
  // every Avalon output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
`ifdef DECA_ENET_RST_READBACK_EN
      read_reg  <= 1'b0;
      error_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_WR_ASSERT;
            busy_reg  <= 1'b1;
            write_reg <= 1'b1;
            addr_reg  <= PIO_ADDR;
            wdata_reg <= PIO_ASSERT_DATA;
`ifdef DECA_ENET_RST_READBACK_EN
            error_reg <= 1'b0;
`endif
          end
        end
        ST_WR_ASSERT: begin
          if (!avm.avm_waitrequest) begin
            state_reg <= ST_HOLD;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
          end
        end
        ST_HOLD: begin
          if (tmr_expire) begin
            state_reg <= ST_WR_RELEASE;
            write_reg <= 1'b1;
            addr_reg  <= PIO_ADDR;
            wdata_reg <= PIO_RELEASE_DATA;
          end
        end
        ST_WR_RELEASE: begin
          if (!avm.avm_waitrequest) begin
            state_reg <= ST_SETTLE;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
          end
        end
        ST_SETTLE: begin
          if (tmr_expire) begin
`ifdef DECA_ENET_RST_READBACK_EN
            state_reg <= ST_RD_REQ;
            read_reg  <= 1'b1;
            addr_reg  <= PIO_ADDR;
`else
            state_reg <= ST_FINISH;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`endif
          end
        end
`ifdef DECA_ENET_RST_READBACK_EN
        ST_RD_REQ: begin
          if (!avm.avm_waitrequest) begin
            state_reg <= ST_RD_WAIT;
            read_reg  <= 1'b0;
            addr_reg  <= '0;
          end
        end
        ST_RD_WAIT: begin
          // A response in the final timeout cycle still counts as valid.
          if (avm.avm_readdatavalid) begin
            state_reg <= ST_FINISH;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            error_reg <= ~avm.avm_readdata[0];
          end else if (tmr_expire) begin
            state_reg <= ST_FINISH;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            error_reg <= 1'b1;
          end
        end
`endif
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          write_reg <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
        end
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign avm.avm_write     = write_reg;
  assign avm.avm_address   = addr_reg;
  assign avm.avm_writedata = wdata_reg;
`ifdef DECA_ENET_RST_READBACK_EN
  assign avm.avm_read      = read_reg;
  assign error             = error_reg;
`else
  assign avm.avm_read      = 1'b0;
  assign error             = 1'b0;
`endif

endmodule

// File: tb/tb_deca_enet_reset_master.sv
// -----------------------------------------------------------------------------
// tb_deca_enet_reset_master
// Directed bench for deca_enet_reset_master with ASSERT_CYCLES=4,
// SETTLE_CYCLES=3, TIMEOUT_CYCLES=8 and a non-zero PIO address. Every cycle
// of each sequence is compared as one vector
// {busy, done, error, write, read, address, writedata}.
// Follows DECA_ENET_RST_READBACK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_deca_enet_reset_master;
  import deca_enet_rst_pkg::*;

  localparam logic [31:0] PIO = 32'h0000_0040;
  localparam int AC = 4;
  localparam int SC = 3;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deca_enet_reset_master_if #(.ADDR_W(32)) avm ();

  deca_enet_reset_master #(
    .ADDR_W         (32),
    .PIO_ADDR       (PIO),
    .ASSERT_CYCLES  (AC),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .error (error),
    .avm   (avm.master)
  );

  // Expected output vector; address must be PIO exactly when a request is up.
  function automatic logic [68:0] ev(input bit b, input bit d, input bit e,
                                     input bit w, input bit r,
                                     input logic [31:0] wd);
    logic [31:0] a;
    a = (w || r) ? PIO : 32'h0;
    return {b, d, e, w, r, a, wd};
  endfunction

  function automatic logic [68:0] x_idle(input bit e); return ev(0, 0, e, 0, 0, 32'd0); endfunction
  function automatic logic [68:0] x_busy();            return ev(1, 0, 0, 0, 0, 32'd0); endfunction
  function automatic logic [68:0] x_w0();              return ev(1, 0, 0, 1, 0, 32'd0); endfunction
  function automatic logic [68:0] x_w1();              return ev(1, 0, 0, 1, 0, 32'd1); endfunction
  function automatic logic [68:0] x_rd();              return ev(1, 0, 0, 0, 1, 32'd0); endfunction
  function automatic logic [68:0] x_done(input bit e); return ev(0, 1, e, 0, 0, 32'd0); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [68:0] exp);
    logic [68:0] obs;
    obs = {busy, done, error, avm.avm_write, avm.avm_read,
           avm.avm_address, avm.avm_writedata};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdata      = 32'd0;
    avm.avm_readdatavalid = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("reset_state", x_idle(0));
    reset = 1'b0;
    tick();
    chk("idle_after_reset", x_idle(0));

    // ---------------- seq 1: nominal, start pulse mid-HOLD ignored ----------
    start = 1'b1; tick(); start = 1'b0;                  // cycle 1
    chk("s1_wr_assert_c1", x_w0());
    tick();
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("s1_hold_c%0d", c), x_busy());
      start = (c == 4);
      tick();
    end
    start = 1'b0;
    chk("s1_wr_release_c6", x_w1());
    tick();
    for (int c = 7; c <= 9; c++) begin
      chk($sformatf("s1_settle_c%0d", c), x_busy());
      tick();
    end
`ifdef DECA_ENET_RST_READBACK_EN
    chk("s1_read_c10", x_rd());
    tick();
    chk("s1_rdwait_c11", x_busy());
    avm.avm_readdatavalid = 1'b1; avm.avm_readdata = 32'd1;
    tick();
    avm.avm_readdatavalid = 1'b0; avm.avm_readdata = 32'd0;
    chk("s1_done_c12", x_done(0));
    tick();
    chk("s1_idle_c13", x_idle(0));
`else
    chk("s1_done_c10", x_done(0));
    tick();
    chk("s1_idle_c11", x_idle(0));
`endif
    $display("seq1 nominal sequence complete, checks so far %0d", checks);
    tick();

    // ---------------- seq 2: waitrequest on first write, readdata=0 --------
    start = 1'b1; tick(); start = 1'b0;                  // cycle 1
    for (int c = 1; c <= 4; c++) begin
      avm.avm_waitrequest = (c < 4);
      chk($sformatf("s2_wr_assert_stall_c%0d", c), x_w0());
      tick();
    end
    avm.avm_waitrequest = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      chk($sformatf("s2_hold_c%0d", c), x_busy());
      tick();
    end
    chk("s2_wr_release_c9", x_w1());
    tick();
    for (int c = 10; c <= 12; c++) begin
      chk($sformatf("s2_settle_c%0d", c), x_busy());
      tick();
    end
`ifdef DECA_ENET_RST_READBACK_EN
    chk("s2_read_c13", x_rd());
    tick();
    chk("s2_rdwait_c14", x_busy());
    avm.avm_readdatavalid = 1'b1; avm.avm_readdata = 32'd0;
    tick();
    avm.avm_readdatavalid = 1'b0;
    chk("s2_done_err_c15", x_done(1));
    tick();
    chk("s2_err_held_c16", x_idle(1));
    tick();
    chk("s2_err_held_c17", x_idle(1));
`else
    chk("s2_done_c13", x_done(0));
    tick();
    chk("s2_idle_c14", x_idle(0));
`endif
    $display("seq2 waitrequest stall sequence complete, checks so far %0d", checks);

`ifdef DECA_ENET_RST_READBACK_EN
    // ---------------- seq 3: readback timeout, late valid ignored ----------
    start = 1'b1; tick(); start = 1'b0;                  // cycle 1
    chk("s3_err_cleared_wr_assert_c1", x_w0());
    tick();
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("s3_hold_c%0d", c), x_busy());
      tick();
    end
    chk("s3_wr_release_c6", x_w1());
    tick();
    for (int c = 7; c <= 9; c++) begin
      chk($sformatf("s3_settle_c%0d", c), x_busy());
      tick();
    end
    chk("s3_read_c10", x_rd());
    tick();
    for (int c = 11; c <= 10 + TC; c++) begin
      chk($sformatf("s3_rdwait_c%0d", c), x_busy());
      tick();
    end
    chk("s3_timeout_done_c19", x_done(1));
    tick();
    chk("s3_idle_c20", x_idle(1));
    avm.avm_readdatavalid = 1'b1; avm.avm_readdata = 32'd1;
    tick();
    avm.avm_readdatavalid = 1'b0; avm.avm_readdata = 32'd0;
    chk("s3_late_valid_ignored_c21", x_idle(1));
    tick();
    chk("s3_late_valid_ignored_c22", x_idle(1));
    $display("seq3 readback timeout sequence complete, checks so far %0d", checks);
`endif

    // ---------------- seq 4: reset mid-HOLD, then clean restart ------------
    start = 1'b1; tick(); start = 1'b0;                  // cycle 1
    chk("s4_wr_assert_c1", x_w0());
    tick();
    chk("s4_hold_c2", x_busy());
    tick();
    chk("s4_hold_c3", x_busy());
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s4_after_reset_c4", x_idle(0));
    tick();
    chk("s4_idle_c5", x_idle(0));
    start = 1'b1; tick(); start = 1'b0;                  // cycle 6
    chk("s4_restart_wr_assert_c6", x_w0());
    tick();
    for (int c = 7; c <= 10; c++) begin
      chk($sformatf("s4_hold_c%0d", c), x_busy());
      tick();
    end
    chk("s4_wr_release_c11", x_w1());
    tick();
    for (int c = 12; c <= 14; c++) begin
      chk($sformatf("s4_settle_c%0d", c), x_busy());
      tick();
    end
`ifdef DECA_ENET_RST_READBACK_EN
    chk("s4_read_c15", x_rd());
    tick();
    avm.avm_readdatavalid = 1'b1; avm.avm_readdata = 32'd1;
    tick();
    avm.avm_readdatavalid = 1'b0; avm.avm_readdata = 32'd0;
    chk("s4_done_c17", x_done(0));
`else
    chk("s4_done_c15", x_done(0));
`endif
    tick();
    chk("s4_final_idle", x_idle(0));
    $display("seq4 reset mid-hold sequence complete, checks so far %0d", checks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
